spi_flash_sequencer: RTL and testbench
======================================

// Module: spi_flash_sequencer
// PURPOSE
// - Shares one SPI flash byte engine between a word-read requester (fetch) and an erase requester.
// - Sequences complete W25Q64-style command transactions:
//   - READ (03h): 4-byte word read.
//   - Erase: WREN (06h), then sector erase (20h) or chip erase (C7h), then RDSR (05h) polling until WIP clears.
// - Owns chip-select timing; the byte engine only shifts bytes.
// PARAMETERS
// - CS_GAP      default 2      cycles cs_n held high between transactions (>=1)
// - POLL_LIMIT  default 65535  max RDSR polls before timeout (used only with timeout feature)
// PORTS
// - ACLK        in   1   clock
// - ARESET      in   1   async reset, active high
// - rd_req      in   1   read request; hold until rd_ack
// - rd_addr     in   24  flash byte address, sampled at grant
// - rd_ack      out  1   1-cycle pulse; rd_data valid same cycle
// - rd_data     out  32  first byte received in [7:0], little-endian
// - er_req      in   1   erase request; hold until er_ack
// - er_chip     in   1   1 = chip erase C7h; 0 = sector erase 20h; sampled at grant
// - er_addr     in   24  sector address, sent as given (no alignment); sampled at grant
// - er_ack      out  1   1-cycle pulse at erase completion
// - er_err      out  1   valid with er_ack; 1 = poll timeout
// - sh_start    out  1   1-cycle pulse: engine shifts sh_tx out
// - sh_tx       out  8   byte to send; stable from sh_start until sh_done
// - sh_done     in   1   1-cycle pulse: byte finished, sh_rx valid
// - sh_rx       in   8   byte received during the last shift
// - cs_n        out  1   flash chip select, active low
// - busy        out  1   high from grant until the ack cycle, inclusive
// - status_reg  out  8   last RDSR byte read
// BEHAVIOUR
// - Reset (async, immediate) values:
//   - cs_n=1, sh_start=0, sh_tx=00h, rd_ack=0, er_ack=0, er_err=0, rd_data=0, status_reg=0, busy=0.
//   - FSM=IDLE, round-robin pointer=read, gap counter=0.
// - Reset mid-transaction aborts it; no ack is issued, and the requester must re-request.
// - Arbitration, in IDLE once the gap counter has expired:
//   - Single request: granted the next cycle.
//   - Both requests: round-robin; the pointer toggles to the other requester after each grant.
//   - Grant latches the address and er_chip.
// - Byte handshake:
//   - One sh_start per byte; the next byte is not started until sh_done.
//   - sh_start never asserted while cs_n=1.
//   - cs_n falls in the same cycle as the first sh_start of a transaction.
//   - cs_n rises the cycle after the last sh_done.
//   - cs_n then stays high at least CS_GAP cycles before it can fall again.
// - States:
//   - IDLE
//   - RD_CMD: 03h
//   - RD_ADDR: addr[23:16], [15:8], [7:0]
//   - RD_DATA: 4 bytes with sh_tx=00h
//   - WREN: 06h, then GAP
//   - ER_CMD: 20h + 3 addr bytes, or C7h alone
//   - GAP
//   - POLL_CMD: 05h
//   - POLL_DATA: 1 byte, sh_tx=00h
//   - ACK
// - Read path: IDLE -> RD_CMD -> RD_ADDR -> RD_DATA -> ACK (rd_ack=1) -> GAP -> IDLE.
// - Erase path: IDLE -> WREN -> GAP -> ER_CMD -> GAP -> POLL_CMD -> POLL_DATA.
// - Each poll is its own cs_n transaction; status_reg <= sh_rx at POLL_DATA sh_done.
// - WIP check:
//   - sh_rx[0]=1: GAP -> POLL_CMD (poll again).
//   - sh_rx[0]=0: ACK (er_ack=1, er_err=0) -> GAP -> IDLE.
// - Byte counter: 2 bits, reset per phase; the phase ends when count==last and sh_done arrives.
// - Request dropped before grant: ignored. Request dropped after grant: the transaction still completes and acks.
// - sh_done outside a shifting phase: ignored.
// CONFIGURATION
// - SPI_SEQ_POLL_TIMEOUT_EN defined:
//   - 16-bit poll counter, cleared at erase grant, incremented at each POLL_DATA sh_done with WIP=1.
//   - When the counter reaches POLL_LIMIT: ACK with er_ack=1, er_err=1.
// - SPI_SEQ_POLL_TIMEOUT_EN undefined:
//   - Polls indefinitely; er_err tied to 0; no counter logic.
// TESTING
// - Reset: ARESET pulsed mid-ER_CMD -> cs_n=1, busy=0, all acks 0 in the same cycle; no er_ack ever follows.
// - Read: rd_addr=000100h, model returns AA BB CC DD
//   - Bytes sent: 03 00 01 00 00 00 00 00 in one cs_n low window.
//   - rd_ack pulses once with rd_data=DDCCBBAAh.
// - Sector erase: er_addr=012345h, er_chip=0, model SR sequence 03, 03, 00
//   - Transactions: [06] gap [20 01 23 45] gap [05 xx] x3.
//   - er_ack after the 3rd poll, er_err=0, status_reg=00h.
// - Contention: rd_req and er_req both high from reset
//   - Read served first, then erase.
//   - rd_req re-asserted during the erase waits; it is served right after er_ack.
// - Chip erase: er_chip=1 -> [06] gap [C7] gap polls; cs_n high >= CS_GAP cycles between every transaction.
// - Timeout, with SPI_SEQ_POLL_TIMEOUT_EN, POLL_LIMIT=4, SR stuck at 01h
//   - Exactly 4 polls, then er_ack=1 with er_err=1.
//   - Without the macro: polling continues past 4.

Source files
------------

// File: rtl/spi_flash_sequencer.sv
// Arbitrates a read requester and an erase requester onto one SPI byte engine and sequences W25Q64-style transactions.
// Optional feature macro: SPI_SEQ_POLL_TIMEOUT_EN (bounds RDSR polling to POLL_LIMIT polls and reports er_err).
module spi_flash_sequencer #(
    parameter int unsigned CS_GAP     = 2,
    parameter int unsigned POLL_LIMIT = 65535
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        rd_req,
    input  logic [23:0] rd_addr,
    output logic        rd_ack,
    output logic [31:0] rd_data,
    input  logic        er_req,
    input  logic        er_chip,
    input  logic [23:0] er_addr,
    output logic        er_ack,
    output logic        er_err,
    output logic        sh_start,
    output logic [7:0]  sh_tx,
    input  logic        sh_done,
    input  logic [7:0]  sh_rx,
    output logic        cs_n,
    output logic        busy,
    output logic [7:0]  status_reg
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_CMD, S_RD_ADDR, S_RD_DATA, S_WREN,
        S_ER_CMD, S_GAP, S_POLL_CMD, S_POLL_DATA, S_ACK
    } state_t;

    localparam logic [15:0] GAP_LOAD = 16'(CS_GAP - 1);

    state_t      state_q, state_d;
    state_t      gap_next_q, gap_next_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        inflight_q, inflight_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        rr_q, rr_d;            // 0: read has priority, 1: erase has priority
    logic        is_rd_q, is_rd_d;
    logic        chip_q, chip_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [7:0]  status_q, status_d;

    logic        shifting;
    logic [1:0]  last;
    logic        byte_done;
    logic        phase_done;
    logic        gnt_rd;
    logic        gnt_er;

`ifdef SPI_SEQ_POLL_TIMEOUT_EN
    localparam logic [15:0] POLL_LIMIT_W = 16'(POLL_LIMIT);
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        err_q, err_d;
`endif

    function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] idx);
        case (idx)
            2'd0:    addr_byte = a[23:16];
            2'd1:    addr_byte = a[15:8];
            default: addr_byte = a[7:0];
        endcase
    endfunction

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            gap_next_q <= S_IDLE;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            gap_cnt_q  <= 16'd0;
            rr_q       <= 1'b0;
            is_rd_q    <= 1'b0;
            chip_q     <= 1'b0;
            addr_q     <= 24'd0;
            rd_data_q  <= 32'd0;
            status_q   <= 8'd0;
`ifdef SPI_SEQ_POLL_TIMEOUT_EN
            poll_cnt_q <= 16'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gap_next_q <= gap_next_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            gap_cnt_q  <= gap_cnt_d;
            rr_q       <= rr_d;
            is_rd_q    <= is_rd_d;
            chip_q     <= chip_d;
            addr_q     <= addr_d;
            rd_data_q  <= rd_data_d;
            status_q   <= status_d;
`ifdef SPI_SEQ_POLL_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path through the case infers a latch.
        state_d    = state_q;
        gap_next_d = gap_next_q;
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        gap_cnt_d  = gap_cnt_q;
        rr_d       = rr_q;
        is_rd_d    = is_rd_q;
        chip_d     = chip_q;
        addr_d     = addr_q;
        rd_data_d  = rd_data_q;
        status_d   = status_q;
`ifdef SPI_SEQ_POLL_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        err_d      = err_q;
`endif
        sh_start   = 1'b0;
        sh_tx      = 8'h00;
        shifting   = 1'b0;
        last       = 2'd0;
        byte_done  = 1'b0;
        gnt_rd     = 1'b0;
        gnt_er     = 1'b0;

        case (state_q)
            S_RD_CMD:    begin shifting = 1'b1; sh_tx = 8'h03; end
            S_RD_ADDR:   begin shifting = 1'b1; last = 2'd2; sh_tx = addr_byte(addr_q, cnt_q); end
            S_RD_DATA:   begin shifting = 1'b1; last = 2'd3; end
            S_WREN:      begin shifting = 1'b1; sh_tx = 8'h06; end
            S_ER_CMD: begin
                shifting = 1'b1;
                if (chip_q) begin
                    sh_tx = 8'hC7;
                end else begin
                    last  = 2'd3;
                    sh_tx = (cnt_q == 2'd0) ? 8'h20 : addr_byte(addr_q, cnt_q - 2'd1);
                end
            end
            S_POLL_CMD:  begin shifting = 1'b1; sh_tx = 8'h05; end
            S_POLL_DATA: begin shifting = 1'b1; end
            default:     ;
        endcase

        // One byte in flight at a time; sh_done is only honoured while a byte is outstanding.
        if (shifting) begin
            if (!inflight_q) begin
                sh_start   = 1'b1;
                inflight_d = 1'b1;
            end else if (sh_done) begin
                inflight_d = 1'b0;
                byte_done  = 1'b1;
                cnt_d      = (cnt_q == last) ? 2'd0 : cnt_q + 2'd1;
            end
        end
        phase_done = byte_done && (cnt_q == last);
        cs_n       = ~shifting;

        case (state_q)
            S_IDLE: begin
                if (gap_cnt_q == 16'd0) begin
                    gnt_rd = rd_req && (!er_req || !rr_q);
                    gnt_er = er_req && !gnt_rd;
                end
                if (gnt_rd) begin
                    state_d = S_RD_CMD;
                    is_rd_d = 1'b1;
                    addr_d  = rd_addr;
                    rr_d    = 1'b1;
                    cnt_d   = 2'd0;
                end else if (gnt_er) begin
                    state_d = S_WREN;
                    is_rd_d = 1'b0;
                    addr_d  = er_addr;
                    chip_d  = er_chip;
                    rr_d    = 1'b0;
                    cnt_d   = 2'd0;
`ifdef SPI_SEQ_POLL_TIMEOUT_EN
                    poll_cnt_d = 16'd0;
                    err_d      = 1'b0;
`endif
                end
            end
            S_RD_CMD:  if (phase_done) state_d = S_RD_ADDR;
            S_RD_ADDR: if (phase_done) state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (byte_done) rd_data_d[{cnt_q, 3'b000} +: 8] = sh_rx;
                if (phase_done) state_d = S_ACK;
            end
            S_WREN: if (phase_done) begin
                state_d    = S_GAP;
                gap_next_d = S_ER_CMD;
                gap_cnt_d  = GAP_LOAD;
            end
            S_ER_CMD: if (phase_done) begin
                state_d    = S_GAP;
                gap_next_d = S_POLL_CMD;
                gap_cnt_d  = GAP_LOAD;
            end
            S_POLL_CMD: if (phase_done) state_d = S_POLL_DATA;
            S_POLL_DATA: if (phase_done) begin
                status_d = sh_rx;
                if (sh_rx[0]) begin
`ifdef SPI_SEQ_POLL_TIMEOUT_EN
                    poll_cnt_d = poll_cnt_q + 16'd1;
                    if (poll_cnt_d == POLL_LIMIT_W) begin
                        state_d = S_ACK;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = S_GAP;
                        gap_next_d = S_POLL_CMD;
                        gap_cnt_d  = GAP_LOAD;
                    end
`else
                    state_d    = S_GAP;
                    gap_next_d = S_POLL_CMD;
                    gap_cnt_d  = GAP_LOAD;
`endif
                end else begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d    = S_GAP;
                gap_next_d = S_IDLE;
                gap_cnt_d  = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_cnt_q == 16'd0) state_d = gap_next_q;
                else                    gap_cnt_d = gap_cnt_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_ack     = (state_q == S_ACK) && is_rd_q;
    assign er_ack     = (state_q == S_ACK) && !is_rd_q;
    assign rd_data    = rd_data_q;
    assign status_reg = status_q;
    // The trailing gap after an ack belongs to no requester.
    assign busy       = (state_q != S_IDLE) && !((state_q == S_GAP) && (gap_next_q == S_IDLE));

`ifdef SPI_SEQ_POLL_TIMEOUT_EN
    assign er_err = er_ack && err_q;
`else
    assign er_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Directed bench for spi_flash_sequencer with a behavioural SPI flash byte-engine model.
module tb_spi_flash_sequencer;
    localparam int CS_GAP = 2;
    localparam logic [8:0] MK = 9'h100;  // cs_n rising marker in the byte log

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        rd_req = 1'b0;
    logic [23:0] rd_addr = 24'd0;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        er_req = 1'b0;
    logic        er_chip = 1'b0;
    logic [23:0] er_addr = 24'd0;
    logic        er_ack;
    logic        er_err;
    logic        sh_start;
    logic [7:0]  sh_tx;
    logic        sh_done = 1'b0;
    logic [7:0]  sh_rx = 8'h00;
    logic        cs_n;
    logic        busy;
    logic [7:0]  status_reg;

    spi_flash_sequencer #(.CS_GAP(CS_GAP), .POLL_LIMIT(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .er_req(er_req), .er_chip(er_chip), .er_addr(er_addr), .er_ack(er_ack), .er_err(er_err),
        .sh_start(sh_start), .sh_tx(sh_tx), .sh_done(sh_done), .sh_rx(sh_rx),
        .cs_n(cs_n), .busy(busy), .status_reg(status_reg)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flash model state
    logic [8:0] log_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] rd_mem[4];
    logic [7:0] sr_list[4];
    int         sr_len = 1;
    int         sr_idx = 0;
    bit         m_busy = 0;
    int         m_lat = 0;
    int         m_idx = 0;
    logic [7:0] m_rx, m_tx, m_cmd, cmd;
    int         proto_viol = 0;
    int         gap_viol = 0;
    int         high_run = CS_GAP;
    logic       prev_cs = 1'b1;
    int         poll_tx = 0;

    always @(negedge ACLK) begin
        if (ARESET) begin
            sh_done  = 1'b0;
            m_busy   = 0;
            m_idx    = 0;
            prev_cs  = 1'b1;
            high_run = CS_GAP;
        end else begin
            sh_done = 1'b0;
            if (m_busy) begin
                if (sh_tx !== m_tx) proto_viol++;
                if (m_lat == 0) begin
                    sh_done = 1'b1;
                    sh_rx   = m_rx;
                    m_busy  = 0;
                end else begin
                    m_lat--;
                end
            end
            if (sh_start === 1'b1) begin
                if (cs_n !== 1'b0 || m_busy) proto_viol++;
                if (m_idx == 0) begin
                    m_cmd = sh_tx;
                    if (sh_tx == 8'h05) poll_tx++;
                end
                cmd  = m_cmd;
                m_rx = 8'hFF;
                if (cmd == 8'h03 && m_idx >= 4 && m_idx < 8) m_rx = rd_mem[m_idx-4];
                if (cmd == 8'h05 && m_idx == 1) begin
                    m_rx = sr_list[sr_idx];
                    if (sr_idx < sr_len - 1) sr_idx++;
                end
                m_tx   = sh_tx;
                m_busy = 1;
                m_lat  = 2;
                m_idx++;
                log_q.push_back({1'b0, sh_tx});
            end
            if (cs_n && !prev_cs) begin
                log_q.push_back(MK);
                m_idx = 0;
            end
            if (!cs_n && prev_cs && high_run < CS_GAP) gap_viol++;
            high_run = cs_n ? high_run + 1 : 0;
            prev_cs  = cs_n;
        end
    end

    // Ack monitor
    int   rd_ack_cnt = 0;
    int   er_ack_cnt = 0;
    int   ack_order[$];
    logic last_er_err = 1'b0;

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (rd_ack) begin rd_ack_cnt++; ack_order.push_back(0); end
            if (er_ack) begin er_ack_cnt++; last_er_err = er_err; ack_order.push_back(1); end
        end
    end

    task automatic wait_ack(input bit er, input int budget, input string tag);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge ACLK);
            got = er ? er_ack : rd_ack;
        end
        if (!got) check({tag, "_ack_timeout"}, 0, 1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
    endtask

    task automatic set_sr(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int len);
        sr_list[0] = a; sr_list[1] = b; sr_list[2] = c; sr_list[3] = c;
        sr_len = len;
        sr_idx = 0;
    endtask

    initial begin
        int snap;
        int dly;
        bit seen;

        // Reset values
        repeat (3) @(negedge ACLK);
        check("rst_cs_n", cs_n, 1);
        check("rst_sh_start", sh_start, 0);
        check("rst_sh_tx", sh_tx, 8'h00);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_er_ack", er_ack, 0);
        check("rst_er_err", er_err, 0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_status", status_reg, 8'h00);
        check("rst_busy", busy, 0);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);

        // Word read
        rd_mem[0] = 8'hAA; rd_mem[1] = 8'hBB; rd_mem[2] = 8'hCC; rd_mem[3] = 8'hDD;
        log_q.delete();
        rd_addr = 24'h000100;
        rd_req  = 1'b1;
        wait_ack(0, 300, "read");
        check("read_busy_at_ack", busy, 1);
        check("read_data", rd_data, 32'hDDCCBBAA);
        rd_req = 1'b0;
        repeat (10) @(negedge ACLK);
        check("read_ack_count", rd_ack_cnt, 1);
        check("read_busy_after", busy, 0);
        exp_q = '{9'h003, 9'h000, 9'h001, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, MK};
        compare_log("read_log");

        // Sector erase
        log_q.delete();
        poll_tx = 0;
        set_sr(8'h03, 8'h03, 8'h00, 3);
        er_addr = 24'h012345;
        er_chip = 1'b0;
        er_req  = 1'b1;
        wait_ack(1, 1000, "sector");
        check("sector_err", er_err, 0);
        er_req = 1'b0;
        repeat (10) @(negedge ACLK);
        check("sector_ack_count", er_ack_cnt, 1);
        check("sector_status", status_reg, 8'h00);
        check("sector_polls", poll_tx, 3);
        exp_q = '{9'h006, MK, 9'h020, 9'h001, 9'h023, 9'h045, MK,
                  9'h005, 9'h000, MK, 9'h005, 9'h000, MK, 9'h005, 9'h000, MK};
        compare_log("sector_log");

        // Chip erase
        log_q.delete();
        set_sr(8'h01, 8'h00, 8'h00, 2);
        er_chip = 1'b1;
        er_req  = 1'b1;
        wait_ack(1, 1000, "chip");
        check("chip_err", er_err, 0);
        er_req = 1'b0;
        repeat (10) @(negedge ACLK);
        check("chip_ack_count", er_ack_cnt, 2);
        exp_q = '{9'h006, MK, 9'h0C7, MK, 9'h005, 9'h000, MK, 9'h005, 9'h000, MK};
        compare_log("chip_log");

        // Poll timeout with status stuck busy
        poll_tx = 0;
        set_sr(8'h01, 8'h01, 8'h01, 1);
        er_chip = 1'b0;
        er_req  = 1'b1;
`ifdef SPI_SEQ_POLL_TIMEOUT_EN
        wait_ack(1, 2000, "timeout");
        check("timeout_err", er_err, 1);
        er_req = 1'b0;
        repeat (10) @(negedge ACLK);
        check("timeout_polls", poll_tx, 4);
        check("timeout_status", status_reg, 8'h01);
`else
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge ACLK);
            seen = (poll_tx >= 7);
        end
        check("nolimit_poll_progress", seen, 1);
        check("nolimit_no_ack", er_ack_cnt, 2);
        check("nolimit_status", status_reg, 8'h01);
        set_sr(8'h00, 8'h00, 8'h00, 1);
        wait_ack(1, 1000, "nolimit");
        check("nolimit_err", er_err, 0);
        er_req = 1'b0;
        repeat (10) @(negedge ACLK);
        check("nolimit_polls_past_limit", poll_tx > 4, 1);
`endif
        check("timeout_ack_count", er_ack_cnt, 3);

        // Contention from reset: read first, then erase, then re-requested read
        ARESET = 1'b1;
        rd_addr = 24'h000100;
        er_addr = 24'h0A0000;
        er_chip = 1'b0;
        rd_req  = 1'b1;
        er_req  = 1'b1;
        set_sr(8'h01, 8'h00, 8'h00, 2);
        repeat (2) @(negedge ACLK);
        ack_order.delete();
        ARESET = 1'b0;
        wait_ack(0, 300, "cont_read1");
        check("cont_read1_data", rd_data, 32'hDDCCBBAA);
        rd_req = 1'b0;
        repeat (20) @(negedge ACLK);
        check("cont_erase_busy", busy, 1);
        rd_addr = 24'h000200;
        rd_req  = 1'b1;
        wait_ack(1, 1000, "cont_erase");
        er_req = 1'b0;
        dly  = 0;
        seen = 0;
        for (int i = 1; i <= 50 && !seen; i++) begin
            @(negedge ACLK);
            if (sh_start) begin
                seen = 1;
                dly  = i;
                check("cont_read2_first_byte", sh_tx, 8'h03);
            end
        end
        check("cont_read2_start_delay", dly, 4);
        wait_ack(0, 300, "cont_read2");
        rd_req = 1'b0;
        repeat (10) @(negedge ACLK);
        check("cont_ack_total", ack_order.size(), 3);
        if (ack_order.size() == 3) begin
            check("cont_order0_read", ack_order[0], 0);
            check("cont_order1_erase", ack_order[1], 1);
            check("cont_order2_read", ack_order[2], 0);
        end

        // Reset pulsed mid-ER_CMD aborts without an ack
        snap    = er_ack_cnt;
        er_addr = 24'h012345;
        er_req  = 1'b1;
        seen    = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge ACLK);
            seen = (sh_start === 1'b1) && (sh_tx == 8'h20);
        end
        check("abort_reached_er_cmd", seen, 1);
        @(negedge ACLK);
        check("abort_pre_cs_low", cs_n, 0);
        #2 ARESET = 1'b1;
        #1;
        check("abort_cs_n", cs_n, 1);
        check("abort_busy", busy, 0);
        check("abort_rd_ack", rd_ack, 0);
        check("abort_er_ack", er_ack, 0);
        check("abort_sh_start", sh_start, 0);
        er_req = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        repeat (100) @(negedge ACLK);
        check("abort_no_late_ack", er_ack_cnt, snap);

        check("protocol_violations", proto_viol, 0);
        check("cs_gap_violations", gap_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
